// File: rtl/elevator_pkg.sv
// ============================================================================
// Module     : elevator_pkg
// Description: Shared constants and types for the elevator bank: floor and
//              car counts, field widths, car motion encoding, hall button
//              bit encoding and hall-call slot indexing.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam int NUM_FLOORS = 11;
    localparam int NUM_LIFTS  = 4;
    localparam int FLOOR_W    = 4;
    localparam int LIFT_W     = 2;
    localparam int COST_W     = 5;

    // Car motion as reported by each car; 2'b11 is treated as idle.
    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_DN   = 2'b01,
        DIR_UP   = 2'b10
    } car_dir_e;

    // Hall button pair per floor, same bit order as elevator_system in0..in10.
    localparam int HALL_BTN_UP_BIT = 1;
    localparam int HALL_BTN_DN_BIT = 0;

    // One pending-call slot per (floor, direction): slot = 2*floor + dir.
    localparam int NUM_SLOTS   = 2 * NUM_FLOORS;
    localparam int SLOT_W      = 5;
    localparam int SLOT_DIR_UP = 0;
    localparam int SLOT_DIR_DN = 1;

endpackage

`default_nettype wire

// File: rtl/dispatch_cost.sv
// ============================================================================
// Module     : dispatch_cost
// Description: Combinational car selection for one hall call. Cost per car is
//              |car_floor - call_floor| plus DIR_PENALTY when the car is
//              moving away from the call floor. Cars above the top floor are
//              excluded. Lowest cost wins, ties go to the lowest car index.
// Ports      : i_call_floor  - floor of the call being dispatched
//              i_car_floors  - {car4, car3, car2, car1} floor fields
//              i_car_dirs    - {car4, car3, car2, car1} motion fields
//              o_win_lift    - winning car id (0..3)
//              o_win_vld     - at least one car is eligible
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_cost
    import elevator_pkg::*;
#(
    parameter int DIR_PENALTY = 8
) (
    input  logic [FLOOR_W-1:0]           i_call_floor,
    input  logic [NUM_LIFTS*FLOOR_W-1:0] i_car_floors,
    input  logic [NUM_LIFTS*2-1:0]       i_car_dirs,
    output logic [LIFT_W-1:0]            o_win_lift,
    output logic                         o_win_vld
);

    logic [COST_W-1:0]    w_cost [NUM_LIFTS];
    logic [NUM_LIFTS-1:0] w_elig;
    logic [COST_W-1:0]    w_best;

    for (genvar g = 0; g < NUM_LIFTS; g++) begin : g_car
        logic [FLOOR_W-1:0] w_cf;
        logic [1:0]         w_dir;
        logic [FLOOR_W-1:0] w_dist;
        logic               w_away;

        assign w_cf   = i_car_floors[g*FLOOR_W +: FLOOR_W];
        assign w_dir  = i_car_dirs[g*2 +: 2];
        assign w_dist = (w_cf > i_call_floor) ? (w_cf - i_call_floor)
                                              : (i_call_floor - w_cf);
        assign w_away = ((w_dir == DIR_UP) && (w_cf > i_call_floor)) ||
                        ((w_dir == DIR_DN) && (w_cf < i_call_floor));
        assign w_elig[g] = (w_cf <= FLOOR_W'(NUM_FLOORS - 1));
        // Max 10 + 8 = 18 fits in five bits.
        assign w_cost[g] = {1'b0, w_dist} + (w_away ? COST_W'(DIR_PENALTY) : '0);
    end

    // Strict less-than keeps the earlier (lower index) car on a tie.
    always_comb begin
        o_win_vld  = 1'b0;
        o_win_lift = '0;
        w_best     = '1;
        for (int i = 0; i < NUM_LIFTS; i++) begin
            if (w_elig[i] && (!o_win_vld || (w_cost[i] < w_best))) begin
                o_win_vld  = 1'b1;
                o_win_lift = LIFT_W'(i);
                w_best     = w_cost[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hall_call_dispatcher.sv
// ============================================================================
// Module     : hall_call_dispatcher
// Description: Latches up/down hall calls for an 11-floor, 4-car bank, assigns
//              each pending call to the cheapest car via a round-robin slot
//              scanner, drives per-car hall request vectors and hall lamps,
//              and clears calls when the owning car arrives.
// Ports      : clk, rst (async, active low)
//              hall_up/hall_dn          - hall buttons, bit f = floor f
//              car_floorN/car_dirN      - car position and motion, N = 1..4
//              arrive_vld/lift/floor    - arrival pulse of one car
//              hall_req_liftN           - calls owned by car N, per floor
//              lamp_up/lamp_dn          - pending hall calls
// Options    : HALL_TIMEOUT_EN - revoke ownership after TIMEOUT_CYC cycles
//              without arrival so the call is re-dispatched.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module hall_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int DIR_PENALTY = 8
`ifdef HALL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 200
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  logic [FLOOR_W-1:0]    car_floor1,
    input  logic [FLOOR_W-1:0]    car_floor2,
    input  logic [FLOOR_W-1:0]    car_floor3,
    input  logic [FLOOR_W-1:0]    car_floor4,
    input  logic [1:0]            car_dir1,
    input  logic [1:0]            car_dir2,
    input  logic [1:0]            car_dir3,
    input  logic [1:0]            car_dir4,
    input  logic                  arrive_vld,
    input  logic [LIFT_W-1:0]     arrive_lift,
    input  logic [FLOOR_W-1:0]    arrive_floor,
    output logic [NUM_FLOORS-1:0] hall_req_lift1,
    output logic [NUM_FLOORS-1:0] hall_req_lift2,
    output logic [NUM_FLOORS-1:0] hall_req_lift3,
    output logic [NUM_FLOORS-1:0] hall_req_lift4,
    output logic [NUM_FLOORS-1:0] lamp_up,
    output logic [NUM_FLOORS-1:0] lamp_dn
);

    logic [NUM_SLOTS-1:0]             r_pend;
    logic [NUM_SLOTS-1:0]             r_own_vld;
    logic [NUM_SLOTS-1:0][LIFT_W-1:0] r_owner;
    logic [SLOT_W-1:0]                r_scan;

    logic [NUM_SLOTS-1:0] w_press;
    logic [NUM_SLOTS-1:0] w_clr;
    logic [NUM_SLOTS-1:0] w_asg;
    logic [NUM_SLOTS-1:0] w_tmo;
    logic [LIFT_W-1:0]    w_win_lift;
    logic                 w_win_vld;
    logic                 w_arr_ok;

    logic [NUM_LIFTS-1:0][NUM_FLOORS-1:0] w_req;

    assign w_arr_ok = arrive_vld && (arrive_floor <= FLOOR_W'(NUM_FLOORS - 1));

    // Slot index bits [4:1] are the floor of the visited slot.
    dispatch_cost #(
        .DIR_PENALTY (DIR_PENALTY)
    ) u_cost (
        .i_call_floor (r_scan[SLOT_W-1:1]),
        .i_car_floors ({car_floor4, car_floor3, car_floor2, car_floor1}),
        .i_car_dirs   ({car_dir4, car_dir3, car_dir2, car_dir1}),
        .o_win_lift   (w_win_lift),
        .o_win_vld    (w_win_vld)
    );

`ifdef HALL_TIMEOUT_EN
    logic [NUM_SLOTS-1:0][7:0] r_age;
`endif

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        localparam logic [FLOOR_W-1:0] c_FLOOR = FLOOR_W'(s / 2);

        // No up button on the top floor, no down button on the ground floor.
        if ((s % 2) == SLOT_DIR_UP) begin : g_up
            assign w_press[s] = ((s / 2) != (NUM_FLOORS - 1)) && hall_up[s/2];
        end else begin : g_dn
            assign w_press[s] = ((s / 2) != 0) && hall_dn[s/2];
        end

        assign w_clr[s] = w_arr_ok && (arrive_floor == c_FLOOR) &&
                          r_own_vld[s] && (r_owner[s] == arrive_lift);
        assign w_asg[s] = (r_scan == SLOT_W'(s)) && r_pend[s] &&
                          !r_own_vld[s] && w_win_vld;

`ifdef HALL_TIMEOUT_EN
        assign w_tmo[s] = r_own_vld[s] && (r_age[s] == 8'(TIMEOUT_CYC - 1));
`else
        assign w_tmo[s] = 1'b0;
`endif
    end

    // A press always sets pend, so press beats a simultaneous arrival clear;
    // the clear still drops ownership, forcing a fresh dispatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend    <= '0;
            r_own_vld <= '0;
            r_owner   <= '0;
            r_scan    <= '0;
        end else begin
            r_scan <= (r_scan == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_scan + SLOT_W'(1);
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (w_press[s]) begin
                    r_pend[s] <= 1'b1;
                end else if (w_clr[s]) begin
                    r_pend[s] <= 1'b0;
                end

                if (w_clr[s] || w_tmo[s]) begin
                    r_own_vld[s] <= 1'b0;
                end else if (w_asg[s]) begin
                    r_own_vld[s] <= 1'b1;
                end

                if (w_asg[s]) begin
                    r_owner[s] <= w_win_lift;
                end
            end
        end
    end

`ifdef HALL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_age <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (w_asg[s] || w_clr[s] || w_tmo[s]) begin
                    r_age[s] <= '0;
                end else if (r_own_vld[s]) begin
                    r_age[s] <= r_age[s] + 8'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        w_req = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (r_pend[s] && r_own_vld[s]) begin
                w_req[r_owner[s]][s/2] = 1'b1;
            end
        end
    end

    assign hall_req_lift1 = w_req[0];
    assign hall_req_lift2 = w_req[1];
    assign hall_req_lift3 = w_req[2];
    assign hall_req_lift4 = w_req[3];

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_lamp
        assign lamp_up[f] = r_pend[2*f + SLOT_DIR_UP];
        assign lamp_dn[f] = r_pend[2*f + SLOT_DIR_DN];
    end

endmodule

`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
// ============================================================================
// Module     : tb_hall_call_dispatcher
// Description: Self-checking bench for hall_call_dispatcher. A behavioural
//              model of the pending-call table is compared against every DUT
//              output on each falling edge; directed scenarios pin the model
//              with hand-computed expectations, then random traffic follows.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hall_call_dispatcher;

    localparam int NF  = 11;
    localparam int NS  = 22;
    localparam int PEN = 8;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hall_up = '0;
    logic [10:0] hall_dn = '0;
    logic [3:0]  car_floor [4];
    logic [1:0]  car_dir   [4];
    logic        arrive_vld = 1'b0;
    logic [1:0]  arrive_lift = '0;
    logic [3:0]  arrive_floor = '0;
    logic [10:0] req [4];
    logic [10:0] lamp_up, lamp_dn;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    hall_call_dispatcher dut (
        .clk            (clk),
        .rst            (rst),
        .hall_up        (hall_up),
        .hall_dn        (hall_dn),
        .car_floor1     (car_floor[0]),
        .car_floor2     (car_floor[1]),
        .car_floor3     (car_floor[2]),
        .car_floor4     (car_floor[3]),
        .car_dir1       (car_dir[0]),
        .car_dir2       (car_dir[1]),
        .car_dir3       (car_dir[2]),
        .car_dir4       (car_dir[3]),
        .arrive_vld     (arrive_vld),
        .arrive_lift    (arrive_lift),
        .arrive_floor   (arrive_floor),
        .hall_req_lift1 (req[0]),
        .hall_req_lift2 (req[1]),
        .hall_req_lift3 (req[2]),
        .hall_req_lift4 (req[3]),
        .lamp_up        (lamp_up),
        .lamp_dn        (lamp_dn)
    );

    // ---------------------------------------------------------------- model
    bit m_pend [NS];
    bit m_own  [NS];
    int m_owner[NS];
    int m_age  [NS];
    int m_ptr;

    function automatic int best_car(input int f);
        int best, bc, cf, cost;
        best = -1;
        bc   = 1000;
        for (int c = 0; c < 4; c++) begin
            cf = int'(car_floor[c]);
            if (cf <= 10) begin
                cost = (cf > f) ? cf - f : f - cf;
                if ((car_dir[c] == 2'b10 && cf > f) || (car_dir[c] == 2'b01 && cf < f))
                    cost += PEN;
                if (cost < bc) begin
                    bc   = cost;
                    best = c;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step();
        bit np[NS];
        bit no[NS];
        int nw[NS];
        int na[NS];
        int win, f;
        bit press, clr, asg, tmo;
        win = best_car(m_ptr / 2);
        for (int s = 0; s < NS; s++) begin
            f     = s / 2;
            press = (s % 2 == 0) ? (f != 10 && hall_up[f]) : (f != 0 && hall_dn[f]);
            clr   = arrive_vld && int'(arrive_floor) <= 10 && int'(arrive_floor) == f &&
                    m_own[s] && m_owner[s] == int'(arrive_lift);
            asg   = (s == m_ptr) && m_pend[s] && !m_own[s] && win >= 0;
            tmo   = 1'b0;
`ifdef HALL_TIMEOUT_EN
            tmo   = m_own[s] && m_age[s] == TMO - 1;
`endif
            np[s] = press ? 1'b1 : (clr ? 1'b0 : m_pend[s]);
            no[s] = (clr || tmo) ? 1'b0 : (asg ? 1'b1 : m_own[s]);
            nw[s] = asg ? win : m_owner[s];
            na[s] = (asg || clr || tmo) ? 0 : (m_own[s] ? m_age[s] + 1 : m_age[s]);
        end
        m_pend  = np;
        m_own   = no;
        m_owner = nw;
        m_age   = na;
        m_ptr   = (m_ptr + 1) % NS;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) begin
                m_pend[s]  = 1'b0;
                m_own[s]   = 1'b0;
                m_owner[s] = 0;
                m_age[s]   = 0;
            end
            m_ptr = 0;
        end else begin
            model_step();
        end
    end

    function automatic logic [10:0] exp_req(input int lift);
        logic [10:0] v;
        v = '0;
        for (int s = 0; s < NS; s++)
            if (m_pend[s] && m_own[s] && m_owner[s] == lift) v[s/2] = 1'b1;
        return v;
    endfunction

    function automatic logic [10:0] exp_lamp(input int dir);
        logic [10:0] v;
        v = '0;
        for (int f = 0; f < NF; f++) v[f] = m_pend[2*f + dir];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %03h expected %03h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("lamp_up", lamp_up, exp_lamp(0));
            chk("lamp_dn", lamp_dn, exp_lamp(1));
            chk("req1", req[0], exp_req(0));
            chk("req2", req[1], exp_req(1));
            chk("req3", req[2], exp_req(2));
            chk("req4", req[3], exp_req(3));
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic set_cars(input int f0, f1, f2, f3, input logic [1:0] d0, d1, d2, d3);
        car_floor[0] = 4'(f0); car_floor[1] = 4'(f1);
        car_floor[2] = 4'(f2); car_floor[3] = 4'(f3);
        car_dir[0] = d0; car_dir[1] = d1; car_dir[2] = d2; car_dir[3] = d3;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic press(input bit up, input int f);
        if (up) hall_up[f] = 1'b1; else hall_dn[f] = 1'b1;
        @(negedge clk);
        hall_up = '0;
        hall_dn = '0;
    endtask

    task automatic arrive(input int lift, input int f);
        arrive_vld   = 1'b1;
        arrive_lift  = 2'(lift);
        arrive_floor = 4'(f);
        @(negedge clk);
        arrive_vld = 1'b0;
    endtask

    task automatic wait_req(input string nm, input int lift, input int f, input int budget);
        bit got;
        logic [10:0] v;
        got = 1'b0;
        for (int i = 0; i <= budget && !got; i++) begin
            v = req[lift];
            if (v[f]) got = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s: hall_req_lift%0d[%0d] got 0 expected 1 within %0d cycles",
                     nm, lift + 1, f, budget);
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        logic [10:0] t;
        bit any;
        set_cars(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_lamp_up", lamp_up, 11'h000);
        chk("reset_req4", req[3], 11'h000);
        rst = 1'b1;
        @(negedge clk);

        // Nearest car wins: costs 7,4,3,2.
        set_cars(0, 3, 10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        press(1'b1, 7);
        chk("t1_lamp_up7", 11'(lamp_up[7]), 11'd1);
        wait_req("t1_assign", 3, 7, 23);
        t = req[0] | req[1] | req[2];
        chk("t1_others7", 11'(t[7]), 11'd0);

        // Arrival by a non-owner leaves the call alone.
        arrive(0, 7);
        chk("t4_nonowner_lamp", 11'(lamp_up[7]), 11'd1);
        t = req[3];
        chk("t4_nonowner_req", 11'(t[7]), 11'd1);
        arrive(3, 7);
        chk("t4_owner_lamp", 11'(lamp_up[7]), 11'd0);
        t = req[3];
        chk("t4_owner_req", 11'(t[7]), 11'd0);

        // Press coinciding with owner arrival: stays pending, re-dispatched.
        press(1'b1, 7);
        wait_req("t5_first", 3, 7, 23);
        hall_up[7] = 1'b1;
        arrive(3, 7);
        hall_up = '0;
        chk("t5_lamp_held", 11'(lamp_up[7]), 11'd1);
        t = req[3];
        chk("t5_unowned", 11'(t[7]), 11'd0);
        wait_req("t5_reassign", 3, 7, 23);
        arrive(3, 7);

        // Tie at cost 2 goes to car1.
        set_cars(5, 9, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        press(1'b0, 7);
        chk("t2_lamp_dn7", 11'(lamp_dn[7]), 11'd1);
        wait_req("t2_tie", 0, 7, 23);
        t = req[1];
        chk("t2_car2_clear", 11'(t[7]), 11'd0);
        arrive(0, 7);
        chk("t2_cleared", lamp_dn, 11'h000);

        // Moving-away penalty: car1 cost 10, car2 cost 6.
        set_cars(6, 2, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
        press(1'b1, 8);
        wait_req("t3_penalty", 1, 8, 23);
        t = req[0];
        chk("t3_car1_clear", 11'(t[8]), 11'd0);
        arrive(1, 8);

        // Non-existent buttons.
        hall_up[10] = 1'b1;
        hall_dn[0]  = 1'b1;
        @(negedge clk);
        hall_up = '0;
        hall_dn = '0;
        chk("edge_buttons", lamp_up | lamp_dn, 11'h000);

        // All cars out of range: call stays unassigned.
        set_cars(11, 12, 13, 15, 2'b00, 2'b00, 2'b11, 2'b10);
        press(1'b1, 3);
        any = 1'b0;
        repeat (30) begin
            t = req[0] | req[1] | req[2] | req[3];
            if (t[3]) any = 1'b1;
            @(negedge clk);
        end
        chk("excluded_unassigned", 11'(any), 11'd0);
        chk("excluded_lamp", 11'(lamp_up[3]), 11'd1);
        car_floor[2] = 4'd2;
        wait_req("excluded_recover", 2, 3, 23);
        arrive(2, 3);

`ifdef HALL_TIMEOUT_EN
        set_cars(0, 3, 10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        press(1'b1, 7);
        wait_req("tmo_assign", 3, 7, 23);
        any = 1'b0;
        for (int i = 0; i < 210 && !any; i++) begin
            t = req[3];
            if (!t[7]) any = 1'b1;
            else @(negedge clk);
        end
        chk("tmo_revoked", 11'(any), 11'd1);
        wait_req("tmo_reassign", 3, 7, 23);
        arrive(3, 7);
`endif

        // Asynchronous reset mid-cycle with calls pending.
        set_cars(0, 3, 10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        hall_up[2] = 1'b1; hall_up[4] = 1'b1; hall_up[9] = 1'b1;
        @(negedge clk);
        hall_up = '0;
        repeat (30) @(negedge clk);
        chk("t6_pending", lamp_up, 11'h214);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_lamp_up", lamp_up, 11'h000);
        chk("t6_async_req", req[0] | req[1] | req[2] | req[3], 11'h000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_after_release", lamp_up | lamp_dn, 11'h000);

        // Random traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            hall_up = 11'($urandom & $urandom & $urandom & $urandom);
            hall_dn = 11'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) begin
                car_floor[$urandom_range(0, 3)] = 4'($urandom_range(0, 12));
                car_dir[$urandom_range(0, 3)]   = 2'($urandom_range(0, 3));
            end
            arrive_vld   = ($urandom_range(0, 2) == 0);
            arrive_lift  = 2'($urandom_range(0, 3));
            arrive_floor = 4'($urandom_range(0, 11));
            @(negedge clk);
        end
        hall_up    = '0;
        hall_dn    = '0;
        arrive_vld = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hall_call_dispatcher.md
Name: hall_call_dispatcher

Overview:
- Upstream stage of elevator_system for an 11-floor, 4-car bank.
- Latches hall-call buttons (up/down per floor) and keeps them pending until served.
- Assigns each pending call to the lowest-cost car and drives per-car 11-bit hall request vectors into elevator_system alongside the in-car requests.
- Clears calls when the owning car reports arrival; also drives hall lamp outputs.

Parameters:
- NUM_FLOORS, 11, floors 0..10; sets vector widths.
- FLOOR_W, 4, width of floor-number fields.
- DIR_PENALTY, 8, cost added when a car is moving away from the call floor.
- TIMEOUT_CYC, 200, cycles before an assigned call is revoked (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hall_up  in  11  up-call buttons; bit f = floor f, level or pulse.
- hall_dn  in  11  down-call buttons; bit f = floor f.
- car_floor1..car_floor4  in  4 each  current floor of each car.
- car_dir1..car_dir4  in  2 each  car motion: 2'b10 up, 2'b01 down, 2'b00 idle; 2'b11 treated as idle.
- arrive_vld  in  1  one-cycle pulse: a car stopped with doors opening.
- arrive_lift  in  2  arriving car, 0..3 = car1..car4.
- arrive_floor  in  4  floor of the arrival.
- hall_req_lift1..hall_req_lift4  out  11 each  assigned hall calls per car; bit f set if that car owns any call at floor f.
- lamp_up  out  11  pending up calls.
- lamp_dn  out  11  pending down calls.

Behaviour:
- Reset (rst=0, asynchronous): all pending, owner and valid-owner state cleared; scan pointer = 0; every output = 0.
- State per slot: 22 slots, one per (floor, direction); slot index = 2*f + dir, where up = 0 and down = 1. Each slot holds pend, own_vld and owner[1:0].
- Latch: hall_up[f] or hall_dn[f] high at a clock edge sets pend on that slot; lamp is visible the next cycle.
  - hall_up[10] and hall_dn[0] are ignored.
  - Pressing an already-pending slot has no effect.
- Scanner: a free-running pointer visits one slot per cycle, 0..21, then wraps to 0.
  - If the visited slot has pend=1 and own_vld=0, compute cost for each car in the same cycle.
  - Register owner and own_vld=1 at the end of that cycle.
  - Worst-case press-to-assign latency: 23 cycles.
- Cost: d = |car_floor - f|, 4 bits. Add DIR_PENALTY when the car is moving away from f:
  - dir up and car_floor > f, or
  - dir down and car_floor < f.
  - Cost width is 5 bits; maximum 18, no overflow.
  - Minimum cost wins; ties go to the lowest car index.
  - A car with car_floor > 10 is excluded. If all cars are excluded, the slot stays unassigned.
- Outputs: hall_req_liftN[f] = OR over the two slots at floor f of (pend & own_vld & owner == N-1). lamp_up/lamp_dn = pend bits. All outputs are registered or decoded from registered state only.
- Arrival: arrive_vld with arrive_floor <= 10 clears pend and own_vld on both slots at that floor whose owner == arrive_lift.
  - Unassigned and other-owned slots are untouched.
  - arrive_floor > 10 is ignored.
  - Effect appears on outputs the next cycle.
- Simultaneous events on one slot:
  - Arrival-clear and scanner-assign together: clear wins.
  - Arrival-clear and new press together: press wins; the slot ends pend=1, own_vld=0 and is re-dispatched on the next visit.
- An assigned slot is never reassigned, except under the optional feature.

Optional Feature:
- Macro: HALL_TIMEOUT_EN.
- Defined:
  - Each slot has an 8-bit age counter, zeroed on assignment and incremented each cycle while own_vld=1.
  - At TIMEOUT_CYC, own_vld clears while pend stays set; the slot is re-dispatched by the normal scan, and the previous owner may win again.
  - Arrival clears the counter.
- Undefined: no counters; ownership holds until arrival.

Decomposition:
- Shared package elevator_pkg:
  - NUM_FLOORS, NUM_LIFTS=4, FLOOR_W.
  - Direction encodings DIR_UP=2'b10, DIR_DN=2'b01, DIR_IDLE=2'b00.
  - Hall button bit encoding: bit1 up, bit0 down, matching elevator_system's in0..in10.
  - Slot index helper constants.
- One natural sub-module: dispatch_cost, combinational; takes the call floor and direction plus four car floor/dir pairs, and returns the winning car id and a valid flag.

Test Plan:
1. Cars at 0,3,10,5 idle; pulse hall_up[7] for 1 cycle -> lamp_up[7]=1 next cycle; within 23 cycles hall_req_lift4[7]=1 (cost 2); other cars bit 7 = 0.
2. Tie: car1=5, car2=9 idle, car3=car4=0; hall_dn[7] -> hall_req_lift1[7]=1 (both cost 2, lowest index).
3. Penalty: car1=6 dir 2'b01, car2=2 idle, car3/car4 at 0 idle; hall_up[8] -> car1 cost 10, car2 cost 6 -> hall_req_lift2[8]=1.
4. After test 1: arrive_vld=1, arrive_lift=3, arrive_floor=7 -> next cycle lamp_up[7]=0, hall_req_lift4[7]=0; an arrival with arrive_lift=0 at floor 7 instead leaves both set.
5. Press hall_up[7] in the same cycle as the test-4 arrival -> lamp_up[7] stays 1, hall_req_lift4[7]=0 for at least one cycle, then re-assigned within 23 cycles.
6. Drive rst=0 mid-scan with calls pending at floors 2, 4, 9 -> all outputs 0 without waiting for a clock edge; after release, no lamps until new presses. With HALL_TIMEOUT_EN and no arrival, an assigned call is revoked after 200 cycles and re-assigned.
